// File: rtl/d_bcd_to_dec_stream.sv
// BCD digit stream to one-hot decimal, buffered through a small FIFO.
// Invalid codes (10..15) are kept in order, flagged, and counted.
module d_bcd_to_dec_stream #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERRW  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_bcd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [9:0]               out_dec,
    output logic                     out_err,
    input  logic                     err_clr,
    output logic [ERRW-1:0]          err_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [9:0]    mem_dec [DEPTH];
    logic          mem_err [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [9:0]    dec_in;
    logic          err_in;
    logic          push;
    logic          pop;

    always_comb begin
        dec_in = '0;
        err_in = 1'b0;
        if (in_bcd < 4'd10) begin
            dec_in = 10'd1 << in_bcd;
        end else begin
            err_in = 1'b1;
        end
    end

    // Ready is gated by rst so it drops immediately while reset is held.
    assign in_ready  = !rst && (level < LW'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_dec   = out_valid ? mem_dec[rd_ptr] : '0;
    assign out_err   = out_valid ? mem_err[rd_ptr] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_dec[i] <= '0;
                mem_err[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_dec[wr_ptr] <= dec_in;
                mem_err[wr_ptr] <= err_in;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= (push && err_in) ? ERRW'(1) : '0;
        end else if (push && err_in && !(&err_count)) begin
            err_count <= err_count + ERRW'(1);
        end
    end

endmodule

// File: tb/tb_d_bcd_to_dec_stream.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_d_bcd_to_dec_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_bcd = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] out_dec;
    logic       out_err;
    logic       err_clr = 1'b0;
    logic [7:0] err_count;
    logic [2:0] level;

    int total  = 0;
    int passed = 0;

    d_bcd_to_dec_stream #(.DEPTH(4), .ERRW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dec   (out_dec),
        .out_err   (out_err),
        .err_clr   (err_clr),
        .err_count (err_count),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] bcd;
        logic       ordy;
        logic       ev;
        logic [9:0] edec;
        logic       eerr;
        int         elvl;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int ref_dec(input int code);
        return (code < 10) ? (1 << code) : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        err_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_hold(input int code);
        in_valid = 1'b1;
        in_bcd = 4'(code);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        out_ready = 1'b0;
    endtask

    int q[$];
    int m_err;

    initial begin
        tbl[0] = '{1'b1, 4'd3,  1'b0, 1'b1, 10'h008, 1'b0, 1};
        tbl[1] = '{1'b0, 4'd0,  1'b1, 1'b0, 10'h000, 1'b0, 0};
        tbl[2] = '{1'b1, 4'd0,  1'b0, 1'b1, 10'h001, 1'b0, 1};
        tbl[3] = '{1'b1, 4'd9,  1'b0, 1'b1, 10'h001, 1'b0, 2};
        tbl[4] = '{1'b1, 4'd12, 1'b0, 1'b1, 10'h001, 1'b0, 3};
        tbl[5] = '{1'b1, 4'd5,  1'b0, 1'b1, 10'h001, 1'b0, 4};
        tbl[6] = '{1'b0, 4'd0,  1'b1, 1'b1, 10'h200, 1'b0, 3};
        tbl[7] = '{1'b0, 4'd0,  1'b1, 1'b1, 10'h000, 1'b1, 2};
        tbl[8] = '{1'b0, 4'd0,  1'b1, 1'b1, 10'h020, 1'b0, 1};
        tbl[9] = '{1'b0, 4'd0,  1'b1, 1'b0, 10'h000, 1'b0, 0};

        // Reset state while held
        #2;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        do_reset();
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_level", int'(level), 0);
        check("post_rst_err_count", int'(err_count), 0);
        check("post_rst_out_dec", int'(out_dec), 0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].iv;
            in_bcd = tbl[i].bcd;
            out_ready = tbl[i].ordy;
            step();
            check($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
            check($sformatf("tbl%0d_dec", i), int'(out_dec), int'(tbl[i].edec));
            check($sformatf("tbl%0d_err", i), int'(out_err), int'(tbl[i].eerr));
            check($sformatf("tbl%0d_level", i), int'(level), tbl[i].elvl);
            if (i == 5) begin
                check("full_in_ready", int'(in_ready), 0);
                check("full_err_count", int'(err_count), 1);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;

        // Full FIFO, push attempted with pop on the same edge
        for (int c = 1; c <= 4; c++) push_hold(c);
        step();
        check("full_hold_dec", int'(out_dec), ref_dec(1));
        in_valid = 1'b1;
        in_bcd = 4'd8;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("fullpop_level", int'(level), 3);
        check("fullpop_in_ready", int'(in_ready), 1);
        check("fullpop_head", int'(out_dec), ref_dec(2));
        drain();
        check("fullpop_drained", int'(level), 0);

        // Streaming 0..9 three times with pointer wrap
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_err_count", int'(err_count), 0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_bcd = 4'(i % 10);
            step();
            check($sformatf("stream%0d_level", i), int'(level), 1);
            check($sformatf("stream%0d_dec", i), int'(out_dec), ref_dec(i % 10));
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        check("stream_err_count", int'(err_count), 0);
        check("stream_empty", int'(out_valid), 0);

        // Saturation and same-edge clear with invalid push
        in_valid = 1'b1;
        in_bcd = 4'd15;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) step();
        check("sat_err_count", int'(err_count), 255);
        in_bcd = 4'd10;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        in_valid = 1'b0;
        check("clr_push_err_count", int'(err_count), 1);
        check("clr_push_head_err", int'(out_err), 1);
        // Rejected invalid code does not count
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) push_hold(c);
        step();
        check("pre_reject_err_count", int'(err_count), 1);
        in_valid = 1'b1;
        in_bcd = 4'd14;
        step();
        in_valid = 1'b0;
        check("reject_err_count", int'(err_count), 1);
        check("reject_level", int'(level), 4);

        // Asynchronous reset mid-stream
        do_reset();
        for (int c = 6; c < 9; c++) push_hold(c);
        check("pre_arst_level", int'(level), 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_level", int'(level), 0);
        check("arst_in_ready", int'(in_ready), 0);
        check("arst_out_dec", int'(out_dec), 0);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        check("post_arst_in_ready", int'(in_ready), 1);
        check("post_arst_valid", int'(out_valid), 0);
        out_ready = 1'b0;
        push_hold(7);
        check("post_arst_head", int'(out_dec), ref_dec(7));
        check("post_arst_level", int'(level), 1);

        // Randomized run against the queue model
        do_reset();
        q.delete();
        m_err = 0;
        for (int i = 0; i < 2000; i++) begin
            bit acc, pp, bad;
            in_valid = 1'($urandom_range(0, 1));
            in_bcd = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 2) != 0);
            err_clr = ($urandom_range(0, 63) == 0);
            acc = in_valid && (q.size() < 4);
            pp = out_ready && (q.size() > 0);
            bad = acc && (in_bcd > 4'd9);
            step();
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(int'(in_bcd));
            if (err_clr) m_err = bad ? 1 : 0;
            else if (bad && m_err < 255) m_err++;
            check($sformatf("rnd%0d_level", i), int'(level), q.size());
            check($sformatf("rnd%0d_in_ready", i), int'(in_ready), int'(q.size() < 4));
            check($sformatf("rnd%0d_valid", i), int'(out_valid), int'(q.size() > 0));
            check($sformatf("rnd%0d_dec", i), int'(out_dec), (q.size() > 0) ? ref_dec(q[0]) : 0);
            check($sformatf("rnd%0d_err", i), int'(out_err),
                  (q.size() > 0) ? int'(q[0] > 9) : 0);
            check($sformatf("rnd%0d_err_count", i), int'(err_count), m_err);
        end
        in_valid = 1'b0;
        err_clr = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
